// File: rtl/exu_lsu_ctrl_pkg.sv
// exu_lsu_ctrl_pkg: shared load/store encodings.
// Size codes, mem_op field positions, FSM states, alignment helper.
package exu_lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'd0,
        LSU_SIZE_H = 2'd1,
        LSU_SIZE_W = 2'd2,
        LSU_SIZE_X = 2'd3
    } lsu_size_e;

    // mem_op = {is_store, unsigned, size[1:0]}
    localparam int unsigned OP_STORE_BIT = 3;
    localparam int unsigned OP_UNS_BIT   = 2;
    localparam int unsigned OP_SIZE_LSB  = 0;

    typedef struct packed {
        logic      store;
        logic      uns;
        lsu_size_e size;
    } lsu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } lsu_state_e;

    // Size 3 has no encoding, so it is always treated as a fault.
    function automatic logic lsu_misaligned(
        input lsu_size_e  size,
        input logic [1:0] lo
    );
        logic bad;
        case (size)
            LSU_SIZE_B: bad = 1'b0;
            LSU_SIZE_H: bad = lo[0];
            LSU_SIZE_W: bad = |lo;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/exu_lsu_ctrl_if.sv
// exu_lsu_ctrl_if: req/gnt/rvalid memory bus.
// master drives req/addr/we/sel/wdata; slave returns gnt/rvalid/rdata.
interface exu_lsu_ctrl_if;

    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, sel, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, sel, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/exu_lsu_ctrl_lsu_lane_align.sv
// lsu_lane_align: byte-lane select, store replication, load extract.
// Ports: i_addr_lo/i_size/i_uns/i_rs2/i_rdata -> o_sel/o_wdata/o_ldata.
module lsu_lane_align
    import exu_lsu_ctrl_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  lsu_size_e   i_size,
    input  logic        i_uns,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);

    logic [31:0] w_shift;
    logic        w_fill;

    // Move the addressed lane down to bit 0 before extending.
    assign w_shift = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_sel   = 4'b1111;
        o_wdata = i_rs2;
        o_ldata = i_rdata;
        w_fill  = 1'b0;
        case (i_size)
            LSU_SIZE_B: begin
                o_sel   = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_rs2[7:0]}};
                w_fill  = ~i_uns & w_shift[7];
                o_ldata = {{24{w_fill}}, w_shift[7:0]};
            end
            LSU_SIZE_H: begin
                o_sel   = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_rs2[15:0]}};
                w_fill  = ~i_uns & w_shift[15];
                o_ldata = {{16{w_fill}}, w_shift[15:0]};
            end
            default: begin
                o_sel   = 4'b1111;
                o_wdata = i_rs2;
                o_ldata = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/exu_lsu_ctrl.sv
// exu_lsu_ctrl: execute-stage load/store sequencer.
// Ports: clk/rst; dispatch req_mem/op/data in; dp_* to the shared
// ALU for the address; bus master (req/gnt/rvalid); stall_o;
// wb_valid/wb_data load result; misalign/buserr pulses + exc_addr.
module exu_lsu_ctrl
    import exu_lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_mem_i,
    input  logic [31:0]           mem_op1_i,
    input  logic [31:0]           mem_op2_i,
    input  logic [31:0]           mem_wdata_i,
    input  logic [3:0]            mem_op_i,
    output logic                  dp_req_mem_o,
    output logic [31:0]           dp_op1_o,
    output logic [31:0]           dp_op2_o,
    input  logic [31:0]           dp_res_i,
    exu_lsu_ctrl_if.master        bus,
    output logic                  stall_o,
    output logic                  wb_valid_o,
    output logic [31:0]           wb_data_o,
    output logic                  exc_misalign_o,
    output logic                  exc_buserr_o,
    output logic [31:0]           exc_addr_o
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST =
        CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);
    localparam bit LP_TO_EN = (TIMEOUT_CYCLES != 0);

    lsu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    lsu_op_t          r_op;
    logic [3:0]       r_sel;
    logic [31:0]      r_wdata;
    logic             r_wb_valid;
    logic [31:0]      r_wb_data;
    logic             r_exc_mis;
    logic             r_exc_bus;
    logic [31:0]      r_exc_addr;

    lsu_op_t          w_op;
    logic             w_idle;
    logic             w_in_req;
    logic             w_misal;
    logic             w_expire;
    logic [1:0]       w_lane_lo;
    lsu_size_e        w_lane_size;
    logic             w_lane_uns;
    logic [3:0]       w_sel;
    logic [31:0]      w_wdata;
    logic [31:0]      w_ldata;

    assign w_op = '{
        store: mem_op_i[OP_STORE_BIT],
        uns:   mem_op_i[OP_UNS_BIT],
        size:  lsu_size_e'(mem_op_i[OP_SIZE_LSB +: 2])
    };

    assign w_idle   = (r_state == ST_IDLE);
    assign w_in_req = (r_state == ST_REQ);
    assign w_misal  = lsu_misaligned(w_op.size, dp_res_i[1:0]);
    assign w_expire = LP_TO_EN && (r_cnt == LP_CNT_LAST);

    // One aligner serves both directions: in IDLE it builds the
    // store lanes from the fresh address, afterwards it extracts
    // load data using the latched address/op.
    assign w_lane_lo   = w_idle ? dp_res_i[1:0] : r_addr[1:0];
    assign w_lane_size = w_idle ? w_op.size : r_op.size;
    assign w_lane_uns  = w_idle ? w_op.uns : r_op.uns;

    lsu_lane_align u_align (
        .i_addr_lo (w_lane_lo),
        .i_size    (w_lane_size),
        .i_uns     (w_lane_uns),
        .i_rs2     (mem_wdata_i),
        .i_rdata   (bus.rdata),
        .o_sel     (w_sel),
        .o_wdata   (w_wdata),
        .o_ldata   (w_ldata)
    );

    assign dp_req_mem_o = req_mem_i & w_idle;
    assign dp_op1_o     = w_idle ? mem_op1_i : '0;
    assign dp_op2_o     = w_idle ? mem_op2_i : '0;

    assign stall_o = ~w_idle | (req_mem_i & ~w_misal);

    // Bus fields are only meaningful while requesting; zero otherwise.
    assign bus.req   = w_in_req;
    assign bus.addr  = w_in_req ? {r_addr[31:2], 2'b00} : '0;
    assign bus.we    = w_in_req & r_op.store;
    assign bus.sel   = w_in_req ? r_sel : '0;
    assign bus.wdata = w_in_req ? r_wdata : '0;

    assign wb_valid_o     = r_wb_valid;
    assign wb_data_o      = r_wb_data;
    assign exc_misalign_o = r_exc_mis;
    assign exc_buserr_o   = r_exc_bus;
    assign exc_addr_o     = r_exc_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_op       <= '{store: 1'b0, uns: 1'b0, size: LSU_SIZE_B};
            r_sel      <= '0;
            r_wdata    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_exc_mis  <= 1'b0;
            r_exc_bus  <= 1'b0;
            r_exc_addr <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            r_exc_mis  <= 1'b0;
            r_exc_bus  <= 1'b0;
            r_cnt      <= r_cnt + LP_CNT_ONE;
            unique case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (req_mem_i) begin
                        if (w_misal) begin
                            r_exc_mis  <= 1'b1;
                            r_exc_addr <= dp_res_i;
                        end else begin
                            r_state <= ST_REQ;
                            r_addr  <= dp_res_i;
                            r_op    <= w_op;
                            r_sel   <= w_sel;
                            r_wdata <= w_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    // A grant on the expiry cycle still wins.
                    if (bus.gnt) begin
                        r_cnt <= '0;
                        if (r_op.store) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT_RSP;
                        end
                    end else if (w_expire) begin
                        r_exc_bus  <= 1'b1;
                        r_exc_addr <= r_addr;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_WAIT_RSP: begin
                    if (bus.rvalid) begin
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= w_ldata;
                        r_state    <= ST_IDLE;
                    end else if (w_expire) begin
                        r_exc_bus  <= 1'b1;
                        r_exc_addr <= r_addr;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// tb_exu_lsu_ctrl: directed bench for the load/store sequencer.
// Timeout shortened to 4 cycles to reach the bus-error path quickly.
module tb_exu_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_mem;
    logic [31:0] op1, op2, wdata;
    logic [3:0]  mop;
    logic        dp_req;
    logic [31:0] dp_op1, dp_op2, dp_res;
    logic        stall, wbv, exc_mis, exc_bus;
    logic [31:0] wbd, exc_addr;

    int total = 0;
    int bad   = 0;

    exu_lsu_ctrl_if bus_if ();

    always #5 clk = ~clk;

    // Behavioural ALU: effective address = op1 + op2.
    assign dp_res = dp_op1 + dp_op2;

    exu_lsu_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_mem_i      (req_mem),
        .mem_op1_i      (op1),
        .mem_op2_i      (op2),
        .mem_wdata_i    (wdata),
        .mem_op_i       (mop),
        .dp_req_mem_o   (dp_req),
        .dp_op1_o       (dp_op1),
        .dp_op2_o       (dp_op2),
        .dp_res_i       (dp_res),
        .bus            (bus_if),
        .stall_o        (stall),
        .wb_valid_o     (wbv),
        .wb_data_o      (wbd),
        .exc_misalign_o (exc_mis),
        .exc_buserr_o   (exc_bus),
        .exc_addr_o     (exc_addr)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag,
                        input logic obs,
                        input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] d,
                         input logic [3:0]  o);
        req_mem = 1'b1;
        op1     = a;
        op2     = b;
        wdata   = d;
        mop     = o;
    endtask

    task automatic drop();
        req_mem = 1'b0;
        op1     = '0;
        op2     = '0;
        wdata   = '0;
        mop     = '0;
    endtask

    // Byte load with immediate grant and rvalid one cycle later.
    task automatic byte_load(input string tag,
                             input logic [3:0]  o,
                             input logic [31:0] rd,
                             input logic [31:0] exp_wb);
        issue(32'h2000, 32'h3, 32'h0, o);
        smp();
        nxt();
        drop();
        bus_if.gnt = 1'b1;
        smp();
        chk({tag, "_sel"}, 32'(bus_if.sel), 32'h8);
        chk({tag, "_addr"}, bus_if.addr, 32'h2000);
        nxt();
        bus_if.gnt    = 1'b0;
        bus_if.rvalid = 1'b1;
        bus_if.rdata  = rd;
        smp();
        nxt();
        bus_if.rvalid = 1'b0;
        bus_if.rdata  = '0;
        smp();
        chkb({tag, "_wbv"}, wbv, 1'b1);
        chk({tag, "_wbd"}, wbd, exp_wb);
        nxt();
    endtask

    initial begin
        rst           = 1'b1;
        bus_if.gnt    = 1'b0;
        bus_if.rvalid = 1'b0;
        bus_if.rdata  = '0;
        drop();
        nxt();
        nxt();
        rst = 1'b0;
        smp();
        chkb("rst_stall", stall, 1'b0);
        chkb("rst_req", bus_if.req, 1'b0);
        chkb("rst_wbv", wbv, 1'b0);
        chkb("rst_mis", exc_mis, 1'b0);
        chkb("rst_bus", exc_bus, 1'b0);
        chk("rst_exca", exc_addr, 32'h0);
        chk("rst_wbd", wbd, 32'h0);
        nxt();

        // LW 0x1000+4, gnt at cycle 1, rvalid at cycle 3.
        issue(32'h1000, 32'h4, 32'h0, 4'b0010);
        smp();
        chkb("lw_dpreq", dp_req, 1'b1);
        chk("lw_dpop1", dp_op1, 32'h1000);
        chkb("lw_stall0", stall, 1'b1);
        chkb("lw_req0", bus_if.req, 1'b0);
        nxt();
        drop();
        bus_if.gnt = 1'b1;
        smp();
        chkb("lw_req1", bus_if.req, 1'b1);
        chk("lw_addr", bus_if.addr, 32'h1004);
        chk("lw_sel", 32'(bus_if.sel), 32'hF);
        chkb("lw_we", bus_if.we, 1'b0);
        chkb("lw_stall1", stall, 1'b1);
        chkb("lw_dpreq_busy", dp_req, 1'b0);
        nxt();
        bus_if.gnt = 1'b0;
        smp();
        chkb("lw_req_wait", bus_if.req, 1'b0);
        chkb("lw_stall2", stall, 1'b1);
        nxt();
        bus_if.rvalid = 1'b1;
        bus_if.rdata  = 32'hDEADBEEF;
        smp();
        chkb("lw_stall3", stall, 1'b1);
        chkb("lw_wbv_early", wbv, 1'b0);
        nxt();
        bus_if.rvalid = 1'b0;
        bus_if.rdata  = '0;
        smp();
        chkb("lw_wbv", wbv, 1'b1);
        chk("lw_wbd", wbd, 32'hDEADBEEF);
        chkb("lw_stall4", stall, 1'b0);
        nxt();
        smp();
        chkb("lw_wbv_pulse", wbv, 1'b0);
        nxt();

        // LB / LBU at 0x2003, lane 3 holds 0x80.
        byte_load("lb", 4'b0000, 32'h80FFFFFF, 32'hFFFFFF80);
        byte_load("lbu", 4'b0100, 32'h80FFFFFF, 32'h00000080);

        // SH 0x3002, grant withheld 3 cycles; grant lands on the
        // timeout-expiry cycle and must win.
        issue(32'h3000, 32'h2, 32'h1234ABCD, 4'b1001);
        smp();
        chkb("sh_stall0", stall, 1'b1);
        nxt();
        drop();
        for (int i = 0; i < 4; i++) begin
            bus_if.gnt = (i == 3);
            smp();
            chkb("sh_req", bus_if.req, 1'b1);
            chk("sh_addr", bus_if.addr, 32'h3000);
            chkb("sh_we", bus_if.we, 1'b1);
            chk("sh_sel", 32'(bus_if.sel), 32'hC);
            chk("sh_wdata", bus_if.wdata, 32'hABCDABCD);
            nxt();
        end
        bus_if.gnt = 1'b0;
        smp();
        chkb("sh_idle_req", bus_if.req, 1'b0);
        chkb("sh_idle_stall", stall, 1'b0);
        chkb("sh_no_wbv", wbv, 1'b0);
        chkb("sh_no_buserr", exc_bus, 1'b0);
        nxt();

        // LW at 0x4001: misaligned, no bus access.
        issue(32'h4000, 32'h1, 32'h0, 4'b0010);
        smp();
        chkb("mis_req0", bus_if.req, 1'b0);
        chkb("mis_stall0", stall, 1'b0);
        nxt();
        drop();
        smp();
        chkb("mis_pulse", exc_mis, 1'b1);
        chk("mis_addr", exc_addr, 32'h4001);
        chkb("mis_stall1", stall, 1'b0);
        chkb("mis_req1", bus_if.req, 1'b0);
        nxt();
        smp();
        chkb("mis_pulse_end", exc_mis, 1'b0);
        chk("mis_addr_hold", exc_addr, 32'h4001);
        nxt();

        // LW at 0x5000, granted, rvalid never arrives.
        issue(32'h5000, 32'h0, 32'h0, 4'b0010);
        smp();
        nxt();
        drop();
        bus_if.gnt = 1'b1;
        smp();
        nxt();
        bus_if.gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chkb("to_stall", stall, 1'b1);
            chkb("to_early", exc_bus, 1'b0);
            nxt();
        end
        smp();
        chkb("to_pulse", exc_bus, 1'b1);
        chk("to_addr", exc_addr, 32'h5000);
        chkb("to_stall_end", stall, 1'b0);
        nxt();
        bus_if.rvalid = 1'b1;
        bus_if.rdata  = 32'h11111111;
        smp();
        chkb("to_pulse_end", exc_bus, 1'b0);
        nxt();
        bus_if.rvalid = 1'b0;
        bus_if.rdata  = '0;
        smp();
        chkb("to_stray_wbv", wbv, 1'b0);
        nxt();

        // LW at 0x6000, reset while waiting for the response.
        issue(32'h6000, 32'h0, 32'h0, 4'b0010);
        smp();
        nxt();
        drop();
        bus_if.gnt = 1'b1;
        smp();
        nxt();
        bus_if.gnt = 1'b0;
        rst        = 1'b1;
        smp();
        chkb("rw_stall_pre", stall, 1'b1);
        nxt();
        rst           = 1'b0;
        bus_if.rvalid = 1'b1;
        bus_if.rdata  = 32'h22222222;
        smp();
        chkb("rw_stall", stall, 1'b0);
        chkb("rw_req", bus_if.req, 1'b0);
        chkb("rw_wbv", wbv, 1'b0);
        chk("rw_exca", exc_addr, 32'h0);
        nxt();
        bus_if.rvalid = 1'b0;
        bus_if.rdata  = '0;
        smp();
        chkb("rw_late_wbv", wbv, 1'b0);
        chk("rw_wbd", wbd, 32'h0);
        chkb("rw_late_stall", stall, 1'b0);
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
